// File: rtl/sqrt_arbiter.sv
// ============================================================================
// sqrt_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter that shares a single square-root core among N_REQ
// clients. It chooses a pending requester and registers that client's
// operand. It then pulses sqrt_run and waits for the core's busy output to
// rise and then fall. Finally it captures the root and returns it to the
// granted client with a one-cycle done pulse.
//
// Optional feature (compile-time macro SQRT_ARB_TIMEOUT_EN):
//   This macro enables a watchdog. The watchdog aborts an operation that has
//   spent TIMEOUT cycles waiting on the core. The abort delivers result=0
//   and raises error together with done. When the macro is not defined, the
//   FSM waits indefinitely and error is tied to 0.
//
// Handshake (client side):
//   A client raises req[i] and keeps x_in[i] stable until done[i] pulses.
//   done[i] lasts exactly one cycle, and result is valid in that cycle.
//   Requests are not queued. A client that drops req before it is granted
//   is not served. Once a client is granted, the operation runs to
//   completion even if its req falls.
//
// Ports:
//   clock        in   master clock, rising edge
//   reset        in   asynchronous reset, active-low
//   req          in   [N_REQ]        per-client request
//   x_in         in   [N_REQ*WIDTH]  operands, client i at [i*WIDTH +: WIDTH]
//   done         out  [N_REQ]        one-cycle completion pulse
//   result       out  [WIDTH/2]      root of the granted operand
//   gnt_id       out  [IDW]          index of the client being served
//   busy         out                 high whenever the FSM is not IDLE
//   error        out                 watchdog abort flag, pulses with done
//   sqrt_run     out                 run strobe to the core
//   sqrt_x       out  [WIDTH]        operand to the core, registered at grant
//   sqrt_busy    in                  busy from the core
//   sqrt_result  in   [WIDTH/2]      root from the core
//   fsm_state    out  [3]            current FSM state (debug observation)
// ============================================================================
module sqrt_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64,
    localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int RW     = WIDTH / 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] x_in,
    output logic [N_REQ-1:0]       done,
    output logic [RW-1:0]          result,
    output logic [IDW-1:0]         gnt_id,
    output logic                   busy,
    output logic                   error,
    output logic                   sqrt_run,
    output logic [WIDTH-1:0]       sqrt_x,
    input  logic                   sqrt_busy,
    input  logic [RW-1:0]          sqrt_result,
    output logic [2:0]             fsm_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        DELIVER   = 3'd4
    } state_t;

    state_t         state, state_n;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] pick;
    logic           found;
    logic           timeout_hit;

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;
    logic          err_q;

    assign timeout_hit = (state == WAIT_BUSY || state == WAIT_DONE) &&
                         (wd_cnt == CW'(TIMEOUT - 1));

    // The count covers WAIT_BUSY and WAIT_DONE together. It restarts on any
    // other state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if ((state   == WAIT_BUSY || state   == WAIT_DONE) &&
                     (state_n == WAIT_BUSY || state_n == WAIT_DONE)) begin
            wd_cnt <= wd_cnt + CW'(1);
        end else begin
            wd_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end else if (state == IDLE) begin
            err_q <= 1'b0;
        end
    end

    assign error = (state == DELIVER) && err_q;
`else
    assign timeout_hit = 1'b0;
    assign error       = 1'b0;
`endif

    // Rotating search: start at ptr+1 and wrap. With a single client this
    // reduces to "pick client 0".
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (found) state_n = LAUNCH;
            LAUNCH:    state_n = WAIT_BUSY;
            WAIT_BUSY: if (timeout_hit || sqrt_busy) state_n = timeout_hit ? DELIVER : WAIT_DONE;
            WAIT_DONE: if (timeout_hit || !sqrt_busy) state_n = DELIVER;
            DELIVER:   state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt_id <= '0;
            sqrt_x <= '0;
            result <= '0;
            ptr    <= IDW'(N_REQ - 1);
        end else begin
            if (state == IDLE && found) begin
                gnt_id <= pick;
                sqrt_x <= x_in[int'(pick)*WIDTH +: WIDTH];
            end
            // When the watchdog fires and the core finishes in the same
            // cycle, the abort takes priority.
            if (timeout_hit) begin
                result <= '0;
            end else if (state == WAIT_DONE && !sqrt_busy) begin
                result <= sqrt_result;
            end
            if (state == DELIVER) begin
                ptr <= gnt_id;
            end
        end
    end

    always_comb begin
        done = '0;
        if (state == DELIVER) done[gnt_id] = 1'b1;
    end

    assign busy      = (state != IDLE);
    assign sqrt_run  = (state == LAUNCH);
    assign fsm_state = state;

endmodule

// File: tb/tb_sqrt_arbiter.sv
module tb_sqrt_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int RW    = WIDTH / 2;

  logic                   clock;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] x_in;
  logic [N_REQ-1:0]       done;
  logic [RW-1:0]          result;
  logic [1:0]             gnt_id;
  logic                   busy;
  logic                   error;
  logic                   sqrt_run;
  logic [WIDTH-1:0]       sqrt_x;
  logic                   sqrt_busy;
  logic [RW-1:0]          sqrt_result;
  logic [2:0]             fsm_state;

  int n_checks;
  int n_pass;
  int cyc;

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  sqrt_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .req(req), .x_in(x_in), .done(done),
    .result(result), .gnt_id(gnt_id), .busy(busy), .error(error),
    .sqrt_run(sqrt_run), .sqrt_x(sqrt_x), .sqrt_busy(sqrt_busy),
    .sqrt_result(sqrt_result), .fsm_state(fsm_state)
  );

  // 17-cycle square-root core model
  function automatic logic [15:0] isqrt(input logic [31:0] v);
    logic [15:0] r;
    logic [63:0] sq;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      r[b] = 1'b1;
      sq = 64'(r) * 64'(r);
      if (sq > 64'(v)) r[b] = 1'b0;
    end
    return r;
  endfunction

  logic core_stuck;
  int   core_cnt;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      sqrt_busy   <= 1'b0;
      core_cnt    <= 0;
      sqrt_result <= '0;
    end else if (sqrt_busy) begin
      if (core_cnt == 1) sqrt_busy <= 1'b0;
      core_cnt <= core_cnt - 1;
    end else if (sqrt_run && !core_stuck) begin
      sqrt_busy   <= 1'b1;
      core_cnt    <= 17;
      sqrt_result <= isqrt(sqrt_x);
    end
  end

  // driver tasks
  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    req   = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic set_x(input int c, input logic [WIDTH-1:0] v);
    x_in[c*WIDTH +: WIDTH] = v;
  endtask

  // Waits at negedges for any done; reports client index, cycle and outcome.
  task automatic wait_done(input int limit, output int idx, output int dcyc, output bit ok);
    ok = 1'b0; idx = -1; dcyc = 0;
    for (int n = 0; n < limit; n++) begin
      @(negedge clock);
      if (|done) begin
        ok = 1'b1;
        dcyc = cyc;
        for (int i = 0; i < N_REQ; i++) if (done[i]) idx = i;
        break;
      end
    end
  endtask

  // Serves one request on one client and returns what came back.
  task automatic run_one(input int c, input logic [WIDTH-1:0] v,
                         output int idx, output logic [RW-1:0] res, output bit ok);
    int dcyc;
    @(negedge clock);
    set_x(c, v);
    req = '0;
    req[c] = 1'b1;
    wait_done(60, idx, dcyc, ok);
    res = result;
    req = '0;
    @(negedge clock);
  endtask

  // tests
  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if ({done, result, gnt_id, busy, error, sqrt_run, sqrt_x} !== '0)
      $display("FAIL reset_outputs: got done=%b result=%0d gnt=%0d busy=%b err=%b run=%b x=%0d, want all 0",
               done, result, gnt_id, busy, error, sqrt_run, sqrt_x);
    else n_pass++;
    n_checks++;
    if (fsm_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", fsm_state);
    else n_pass++;
  endtask

  task automatic test_single();
    int idx, dcyc, c0;
    bit ok;
    apply_reset();
    @(negedge clock);
    set_x(0, 32'd144);
    req = 4'b0001;
    c0 = cyc + 1;
    wait_done(40, idx, dcyc, ok);
    n_checks++;
    if (!ok || idx !== 0) $display("FAIL single_done: got ok=%0d idx=%0d want idx 0", ok, idx);
    else n_pass++;
    n_checks++;
    if (dcyc - c0 !== 19) $display("FAIL single_latency: got %0d want 19", dcyc - c0);
    else n_pass++;
    n_checks++;
    if (result !== 16'd12 || gnt_id !== 2'd0 || error !== 1'b0)
      $display("FAIL single_result: got res=%0d gnt=%0d err=%b want 12/0/0", result, gnt_id, error);
    else n_pass++;
    req = '0;
    @(negedge clock);
    n_checks++;
    if (done !== 4'b0000 || result !== 16'd12)
      $display("FAIL single_pulse: got done=%b res=%0d want 0000/12 (held)", done, result);
    else n_pass++;
  endtask

  task automatic test_all_four();
    int idx, dcyc, prev;
    bit ok;
    logic [RW-1:0] exp_res[4];
    exp_res[0] = 16'd4; exp_res[1] = 16'd5; exp_res[2] = 16'd6; exp_res[3] = 16'd7;
    apply_reset();
    @(negedge clock);
    set_x(0, 32'd16); set_x(1, 32'd25); set_x(2, 32'd36); set_x(3, 32'd49);
    req = 4'b1111;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_done(40, idx, dcyc, ok);
      n_checks++;
      if (!ok || idx !== i || result !== exp_res[i])
        $display("FAIL all4_order[%0d]: got ok=%0d idx=%0d res=%0d want idx %0d res %0d",
                 i, ok, idx, result, i, exp_res[i]);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (dcyc - prev !== 21) $display("FAIL all4_period[%0d]: got %0d want 21", i, dcyc - prev);
        else n_pass++;
      end
      prev = dcyc;
      if (idx >= 0) req[idx] = 1'b0;
    end
  endtask

  task automatic test_fairness();
    int idx, dcyc;
    bit ok;
    int exp_id[4];
    exp_id[0] = 0; exp_id[1] = 2; exp_id[2] = 0; exp_id[3] = 2;
    apply_reset();
    @(negedge clock);
    set_x(0, 32'd100); set_x(1, 32'd9); set_x(2, 32'd400); set_x(3, 32'd4);
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_done(40, idx, dcyc, ok);
      n_checks++;
      if (!ok || idx !== exp_id[i] || $countones(done) != 1 ||
          result !== ((exp_id[i] == 0) ? 16'd10 : 16'd20))
        $display("FAIL fair_grant[%0d]: got ok=%0d done=%b res=%0d want client %0d",
                 i, ok, done, result, exp_id[i]);
      else n_pass++;
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    int idx, dcyc;
    bit ok;
    logic [RW-1:0] res;
    apply_reset();
    @(negedge clock);
    set_x(2, 32'd625);
    req = 4'b0100;
    repeat (10) @(negedge clock);
    n_checks++;
    if (fsm_state !== 3'd3 || gnt_id !== 2'd2 || sqrt_x !== 32'd625)
      $display("FAIL mid_setup: got state=%0d gnt=%0d x=%0d want 3/2/625", fsm_state, gnt_id, sqrt_x);
    else n_pass++;
    reset = 1'b0;
    req = '0;
    #1;
    n_checks++;
    if ({done, result, gnt_id, busy, error, sqrt_run, sqrt_x} !== '0)
      $display("FAIL mid_reset: got done=%b res=%0d gnt=%0d busy=%b x=%0d want all 0",
               done, result, gnt_id, busy, sqrt_x);
    else n_pass++;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    wait_done(25, idx, dcyc, ok);
    n_checks++;
    if (ok) $display("FAIL mid_no_done: got done on client %0d want none", idx);
    else n_pass++;
    run_one(1, 32'd81, idx, res, ok);
    n_checks++;
    if (!ok || idx !== 1 || res !== 16'd9)
      $display("FAIL mid_after: got ok=%0d idx=%0d res=%0d want 1/9", ok, idx, res);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int idx, dcyc, c0;
    bit ok;
    apply_reset();
    core_stuck = 1'b1;
    @(negedge clock);
    set_x(3, 32'd49);
    req = 4'b1000;
    c0 = cyc + 1;
`ifdef SQRT_ARB_TIMEOUT_EN
    wait_done(100, idx, dcyc, ok);
    n_checks++;
    if (!ok || idx !== 3 || error !== 1'b1 || result !== 16'd0)
      $display("FAIL timeout_abort: got ok=%0d idx=%0d err=%b res=%0d want 3/1/0", ok, idx, error, result);
    else n_pass++;
    n_checks++;
    if (dcyc - c0 !== 65) $display("FAIL timeout_latency: got %0d want 65", dcyc - c0);
    else n_pass++;
`else
    wait_done(100, idx, dcyc, ok);
    n_checks++;
    if (ok || busy !== 1'b1 || error !== 1'b0)
      $display("FAIL no_timeout: got done_seen=%0d busy=%b err=%b want 0/1/0", ok, busy, error);
    else n_pass++;
`endif
    req = '0;
    core_stuck = 1'b0;
    apply_reset();
  endtask

  task automatic test_edges();
    int idx;
    bit ok;
    logic [RW-1:0] res;
    logic [WIDTH-1:0] xs[3];
    logic [RW-1:0] ex[3];
    xs[0] = 32'd0;         ex[0] = 16'd0;
    xs[1] = 32'hFFFF_FFFF; ex[1] = 16'hFFFF;
    xs[2] = 32'd1;         ex[2] = 16'd1;
    for (int i = 0; i < 3; i++) begin
      run_one(1, xs[i], idx, res, ok);
      n_checks++;
      if (!ok || idx !== 1 || res !== ex[i])
        $display("FAIL edge_x[%0d]: got ok=%0d idx=%0d res=%h want %h", i, ok, idx, res, ex[i]);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0;
    reset = 1'b0; req = '0; x_in = '0; core_stuck = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_reset_mid();
    test_timeout();
    test_edges();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
